// File: rtl/accum_bcd_display.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | accum_bcd_display: serial double-dabble binary->BCD converter driving six     |
// | active-low 7-segment digits, with a one-entry pending buffer.                 |
// | Option macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).              |
// | Revision: 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module accum_bcd_display #(
  parameter int WIDTH = 17
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Value,
  output logic             Busy,
  output logic             Done,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [6:0] c_seg_zero  = 7'b1000000;
  localparam logic [6:0] c_seg_blank = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] c_seg_upper_rst = c_seg_blank;
`else
  localparam logic [6:0] c_seg_upper_rst = c_seg_zero;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sh;
  logic [23:0]        r_bcd;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_pend_val;
  logic               r_pend_vld;
  logic               r_busy;
  logic               r_done;
  logic [6:0]         r_hex [6];

  logic [23:0]        w_bcd_adj;
  logic [5:0]         w_blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction applied before every shift so each nibble stays decimal
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 6; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    w_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only when it and every digit above it are zero
    w_blank[5] = (r_bcd[23:20] == 4'd0);
    for (int i = 4; i >= 1; i--) begin
      w_blank[i] = w_blank[i+1] && (r_bcd[4*i +: 4] == 4'd0);
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_sh       <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pend_val <= '0;
      r_pend_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hex[0]   <= c_seg_zero;
      for (int i = 1; i < 6; i++) begin
        r_hex[i] <= c_seg_upper_rst;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Load) begin
            r_sh    <= Value;
            r_bcd   <= '0;
            r_cnt   <= c_cnt_init;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= (w_bcd_adj << 1) | 24'(r_sh[WIDTH-1]);
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) begin
            r_state <= ST_LATCH;
          end
          if (Load) begin
            r_pend_val <= Value;
            r_pend_vld <= 1'b1;
          end
        end
        ST_LATCH: begin
          r_done <= 1'b1;
          for (int i = 0; i < 6; i++) begin
            r_hex[i] <= w_blank[i] ? c_seg_blank : seg7(r_bcd[4*i +: 4]);
          end
          r_bcd <= '0;
          r_cnt <= c_cnt_init;
          if (r_pend_vld) begin
            r_sh    <= r_pend_val;
            r_state <= ST_SHIFT;
            if (Load) begin
              r_pend_val <= Value;
            end else begin
              r_pend_vld <= 1'b0;
            end
          end else if (Load) begin
            // Nothing pending: start the new value directly, no idle gap
            r_sh    <= Value;
            r_state <= ST_SHIFT;
          end else begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];

endmodule
`default_nettype wire

// File: tb/tb_accum_bcd_display.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | tb_accum_bcd_display: directed self-checking bench for accum_bcd_display.     |
// | Revision: 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module tb_accum_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = 7'b1111111;
`else
  localparam logic [6:0] Z = S0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Load;
  logic [16:0] Value;
  logic        Busy;
  logic        Done;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [41:0] w_hex;

  int n_cmp = 0;
  int n_err = 0;

  accum_bcd_display #(.WIDTH(17)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Value(Value),
    .Busy(Busy), .Done(Done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 Clk = ~Clk;
  assign w_hex = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Single conversion: latency to Done, Busy length, displayed digits, pulse width
  task automatic run_conv(input logic [16:0] v, input logic [41:0] exp_hex, input string tag);
    int lat;
    int busy;
    Load = 1'b1;
    Value = v;
    tick();
    Load = 1'b0;
    busy = Busy ? 1 : 0;
    lat = 0;
    while (!Done && lat < 60) begin
      tick();
      lat++;
      if (Busy) busy++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd18);
    check({tag, "_busy_len"}, 64'(busy), 64'd18);
    check({tag, "_hex"}, 64'(w_hex), 64'(exp_hex));
    tick();
    check({tag, "_done_pulse"}, 64'(Done), 64'd0);
  endtask

  // First value loaded at E0; optional further loads at edges ca and cb
  task automatic two_conv(input logic [16:0] v0,
                          input int ca, input logic [16:0] va,
                          input int cb, input logic [16:0] vb,
                          input logic [41:0] exp1, input logic [41:0] exp2,
                          input string tag);
    int busy = 0, ndone = 0, d1 = 0, d2 = 0;
    logic [41:0] h1 = '0, h2 = '0;
    Load = 1'b1;
    Value = v0;
    tick();
    Load = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      Load  = (c == ca) || (c == cb);
      Value = (c == ca) ? va : vb;
      tick();
      Load = 1'b0;
      if (Busy) busy++;
      if (Done) begin
        ndone++;
        if (ndone == 1) begin d1 = c; h1 = w_hex; end
        else begin d2 = c; h2 = w_hex; end
      end
    end
    check({tag, "_ndone"}, 64'(ndone), 64'd2);
    check({tag, "_done1_at"}, 64'(d1), 64'd18);
    check({tag, "_done2_at"}, 64'(d2), 64'd36);
    check({tag, "_hex1"}, 64'(h1), 64'(exp1));
    check({tag, "_hex2"}, 64'(h2), 64'(exp2));
    check({tag, "_busy_len"}, 64'(busy), 64'd35);
    check({tag, "_busy_end"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    int nd, nb;
    Reset = 1'b1;
    Load  = 1'b0;
    Value = '0;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_hex", 64'(w_hex), 64'({Z, Z, Z, Z, Z, S0}));

    run_conv(17'd0,      {Z, Z, Z, Z, Z, S0},    "v0");
    run_conv(17'd15,     {Z, Z, Z, Z, S1, S5},   "v15");
    run_conv(17'd131071, {S1, S3, S1, S0, S7, S1}, "vmax");

    two_conv(17'd511, 5, 17'd1022, 7, 17'd1024,
             {Z, Z, Z, S5, S1, S1}, {Z, Z, S1, S0, S2, S4}, "pend");
    two_conv(17'd131071, 18, 17'd7, 0, 17'd0,
             {S1, S3, S1, S0, S7, S1}, {Z, Z, Z, Z, Z, S7}, "latch_load");

    // Reset mid-conversion, with an entry sitting in the pending buffer
    run_conv(17'd511, {Z, Z, Z, S5, S1, S1}, "pre_rst");
    Load = 1'b1;
    Value = 17'd1022;
    tick();
    Load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      Load  = (c == 3);
      Value = 17'd99;
      Reset = (c == 8);
      tick();
      Load  = 1'b0;
      Reset = 1'b0;
    end
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_done", 64'(Done), 64'd0);
    check("midrst_hex", 64'(w_hex), 64'({Z, Z, Z, Z, Z, S0}));
    nd = 0;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (Done) nd++;
      if (Busy) nb++;
    end
    check("midrst_no_done", 64'(nd), 64'd0);
    check("midrst_no_busy", 64'(nb), 64'd0);
    run_conv(17'd7, {Z, Z, Z, Z, Z, S7}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
